sub_result_writer: RTL and testbench

SUB_RESULT_WRITER -- requirements
Module: sub_result_writer

---
 rtl/sub_result_writer.sv | 146 ++++++++++++++
 tb/tb_sub_result_writer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sub_result_writer.sv
// Result writer for the SUB stage: buffers int8 result beats in a small FWFT FIFO
// and streams them to memory as word writes with per-element byte enables.
module sub_result_writer #(
    parameter int MAX_VECTOR_SIZE = 8,
    parameter int FIFO_DEPTH      = 8,
    parameter int ADDR_WIDTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [31:0]                  num_elements,
    input  logic [8*MAX_VECTOR_SIZE-1:0] data_in,
    input  logic                         valid_in,
    output logic                         wr_en,
    output logic [ADDR_WIDTH-1:0]        wr_addr,
    output logic [8*MAX_VECTOR_SIZE-1:0] wr_data,
    output logic [MAX_VECTOR_SIZE-1:0]   wr_strb,
    input  logic                         wr_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int DATA_W = 8 * MAX_VECTOR_SIZE;
    localparam logic [31:0] VEC = 32'(MAX_VECTOR_SIZE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state_q;
    logic [DATA_W-1:0]          dataMem [FIFO_DEPTH];
    logic [MAX_VECTOR_SIZE-1:0] strbMem [FIFO_DEPTH];
    logic [PTR_W:0]             wrPtr_q, rdPtr_q;
    logic [31:0]                beatsTotal_q, beatsRecv_q, beatsWritten_q;
    logic [31:0]                beatsRecv_d, beatsWritten_d;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [MAX_VECTOR_SIZE-1:0] lastStrb_q;
    logic                       overflow_q, busy_q, done_q;

    logic                       fifoEmpty, fifoFull, running, wrEnInt;
    logic                       pop, beatWanted, push, drop;
    logic [31:0]                startTotal, startRem;
    logic [MAX_VECTOR_SIZE-1:0] startLastStrb, pushStrb;

    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                       (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
    assign running   = (state_q == RUN);
    assign wrEnInt   = running && !fifoEmpty;
    assign pop       = wrEnInt && wr_ready;

    // Beats past the job length are ignored outright; a full FIFO drops the beat.
    assign beatWanted = running && valid_in && (beatsRecv_q < beatsTotal_q);
    assign push       = beatWanted && (!fifoFull || pop);
    assign drop       = beatWanted && fifoFull && !pop;

    always_comb begin
        startRem       = num_elements % VEC;
        startTotal     = (num_elements / VEC) + 32'(startRem != 32'd0);
        startLastStrb  = (startRem == 32'd0) ? '1 : ~({MAX_VECTOR_SIZE{1'b1}} << startRem);
        pushStrb       = (beatsRecv_q == beatsTotal_q - 32'd1) ? lastStrb_q : '1;
        beatsRecv_d    = beatsRecv_q + 32'(beatWanted);
        beatsWritten_d = beatsWritten_q + 32'(pop) + 32'(drop);
    end

    // Strobe is captured per entry so drops never shift which beat is the last one.
    always_ff @(posedge clk) begin
        if (push) begin
            dataMem[wrPtr_q[PTR_W-1:0]] <= data_in;
            strbMem[wrPtr_q[PTR_W-1:0]] <= pushStrb;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            wrPtr_q        <= '0;
            rdPtr_q        <= '0;
            beatsTotal_q   <= '0;
            beatsRecv_q    <= '0;
            beatsWritten_q <= '0;
            addr_q         <= '0;
            lastStrb_q     <= '0;
            overflow_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        addr_q         <= base_addr;
                        beatsTotal_q   <= startTotal;
                        lastStrb_q     <= startLastStrb;
                        overflow_q     <= 1'b0;
                        beatsRecv_q    <= '0;
                        beatsWritten_q <= '0;
                        wrPtr_q        <= '0;
                        rdPtr_q        <= '0;
                        if (num_elements == 32'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    beatsRecv_q    <= beatsRecv_d;
                    beatsWritten_q <= beatsWritten_d;
                    if (push) wrPtr_q <= wrPtr_q + (PTR_W+1)'(1);
                    if (pop) begin
                        rdPtr_q <= rdPtr_q + (PTR_W+1)'(1);
                        addr_q  <= addr_q + ADDR_WIDTH'(1);
                    end
                    if (drop) overflow_q <= 1'b1;
                    if (beatsWritten_d >= beatsTotal_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_en    = wrEnInt;
    assign wr_addr  = addr_q;
    assign wr_data  = wrEnInt ? dataMem[rdPtr_q[PTR_W-1:0]] : '0;
    assign wr_strb  = wrEnInt ? strbMem[rdPtr_q[PTR_W-1:0]] : '0;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_sub_result_writer.sv
// Directed self-checking bench for sub_result_writer with default parameters
// (8 elements per beat, 8-deep FIFO, 16-bit addresses).
module tb_sub_result_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [31:0] num_elements;
    logic [63:0] data_in;
    logic        valid_in;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_strb;
    logic        wr_ready;
    logic        busy;
    logic        done;
    logic        overflow;

    int checkCount = 0;
    int passCount  = 0;

    sub_result_writer #(
        .MAX_VECTOR_SIZE(8),
        .FIFO_DEPTH(8),
        .ADDR_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .num_elements(num_elements),
        .data_in(data_in),
        .valid_in(valid_in),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_strb(wr_strb),
        .wr_ready(wr_ready),
        .busy(busy),
        .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected) passCount = passCount + 1;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pattern(input int k);
        return 64'h0101_0101_0101_0101 * 64'(k + 1);
    endfunction

    initial begin
        rst = 1'b0; start = 1'b0; base_addr = '0; num_elements = '0;
        data_in = '0; valid_in = 1'b0; wr_ready = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_wr_en", 64'(wr_en), 64'd0);
        checkOutput("reset_wr_addr", 64'(wr_addr), 64'd0);
        checkOutput("reset_wr_data", wr_data, 64'd0);
        checkOutput("reset_flags", {61'd0, busy, done, overflow}, 64'd0);
        rst = 1'b1;
        applyStimulus();

        // Two full beats, memory always ready.
        start = 1'b1; base_addr = 16'h0100; num_elements = 32'd16; wr_ready = 1'b1;
        applyStimulus();
        checkOutput("t1_busy", 64'(busy), 64'd1);
        checkOutput("t1_no_wr_yet", 64'(wr_en), 64'd0);
        start = 1'b0; valid_in = 1'b1; data_in = 64'h1111_2222_3333_4444;
        applyStimulus();
        checkOutput("t1_w0_en", 64'(wr_en), 64'd1);
        checkOutput("t1_w0_addr", 64'(wr_addr), 64'h0100);
        checkOutput("t1_w0_data", wr_data, 64'h1111_2222_3333_4444);
        checkOutput("t1_w0_strb", 64'(wr_strb), 64'hFF);
        data_in = 64'h5555_6666_7777_8888;
        applyStimulus();
        valid_in = 1'b0;
        checkOutput("t1_w1_addr", 64'(wr_addr), 64'h0101);
        checkOutput("t1_w1_data", wr_data, 64'h5555_6666_7777_8888);
        checkOutput("t1_w1_strb", 64'(wr_strb), 64'hFF);
        applyStimulus();
        checkOutput("t1_done", {62'd0, done, busy}, 64'b10);
        checkOutput("t1_done_no_wr", 64'(wr_en), 64'd0);
        applyStimulus();
        checkOutput("t1_done_cleared", 64'(done), 64'd0);

        // Partial final beat: 13 elements leaves 5 valid bytes.
        start = 1'b1; base_addr = 16'h0200; num_elements = 32'd13;
        applyStimulus();
        start = 1'b0; valid_in = 1'b1; data_in = pattern(0);
        applyStimulus();
        checkOutput("t2_w0_strb", 64'(wr_strb), 64'hFF);
        data_in = pattern(1);
        applyStimulus();
        valid_in = 1'b0;
        checkOutput("t2_w1_addr", 64'(wr_addr), 64'h0201);
        checkOutput("t2_w1_strb", 64'(wr_strb), 64'h1F);
        applyStimulus();
        checkOutput("t2_done", 64'(done), 64'd1);
        applyStimulus();
        checkOutput("t2_done_once", 64'(done), 64'd0);

        // Empty job.
        start = 1'b1; base_addr = 16'h0300; num_elements = 32'd0;
        applyStimulus();
        start = 1'b0;
        checkOutput("t3_done", {61'd0, done, busy, wr_en}, 64'b100);
        applyStimulus();
        checkOutput("t3_after", {61'd0, done, busy, wr_en}, 64'b000);

        // Address wrap.
        start = 1'b1; base_addr = 16'hFFFF; num_elements = 32'd16;
        applyStimulus();
        start = 1'b0; valid_in = 1'b1; data_in = pattern(2);
        applyStimulus();
        checkOutput("t4_addr0", 64'(wr_addr), 64'hFFFF);
        data_in = pattern(3);
        applyStimulus();
        valid_in = 1'b0;
        checkOutput("t4_addr1", 64'(wr_addr), 64'h0000);
        applyStimulus();
        checkOutput("t4_done", 64'(done), 64'd1);
        applyStimulus();

        // Stalled memory: 10 beats into an 8-deep FIFO, two are dropped.
        wr_ready = 1'b0;
        start = 1'b1; base_addr = 16'h0300; num_elements = 32'd80;
        applyStimulus();
        start = 1'b0; valid_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            data_in = pattern(k);
            applyStimulus();
            if (k == 2) begin
                checkOutput("t5_stall_addr", 64'(wr_addr), 64'h0300);
                checkOutput("t5_stall_data", wr_data, pattern(0));
            end
        end
        valid_in = 1'b0;
        checkOutput("t5_overflow", 64'(overflow), 64'd1);
        checkOutput("t5_stall_hold", {47'd0, wr_en, wr_addr}, {47'd0, 1'b1, 16'h0300});
        checkOutput("t5_stall_hold_data", wr_data, pattern(0));
        wr_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            checkOutput("t5_drain_en", 64'(wr_en), 64'd1);
            checkOutput("t5_drain_addr", 64'(wr_addr), 64'h0300 + 64'(j));
            checkOutput("t5_drain_data", wr_data, pattern(j));
            applyStimulus();
        end
        checkOutput("t5_done", {61'd0, done, wr_en, overflow}, 64'b101);
        applyStimulus();
        checkOutput("t5_overflow_sticky", 64'(overflow), 64'd1);

        // Reset mid-job with three beats buffered, then a fresh job.
        wr_ready = 1'b0;
        start = 1'b1; base_addr = 16'h0400; num_elements = 32'd80;
        applyStimulus();
        checkOutput("t6_overflow_cleared", {62'd0, busy, overflow}, 64'b10);
        start = 1'b0; valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_in = pattern(k + 4);
            applyStimulus();
        end
        valid_in = 1'b0;
        checkOutput("t6_pending", {47'd0, wr_en, wr_addr}, {47'd0, 1'b1, 16'h0400});
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_async_ctl", {44'd0, wr_en, wr_addr, busy, done, overflow}, 64'd0);
        checkOutput("t6_async_data", {wr_data[55:0], wr_strb}, 64'd0);
        rst = 1'b1;
        applyStimulus();
        checkOutput("t6_idle_after_rst", {62'd0, busy, wr_en}, 64'd0);
        wr_ready = 1'b1;
        start = 1'b1; base_addr = 16'h0500; num_elements = 32'd8;
        applyStimulus();
        start = 1'b0; valid_in = 1'b1; data_in = 64'hDEAD_BEEF_CAFE_F00D;
        applyStimulus();
        valid_in = 1'b0;
        checkOutput("t6_new_addr", 64'(wr_addr), 64'h0500);
        checkOutput("t6_new_data", wr_data, 64'hDEAD_BEEF_CAFE_F00D);
        checkOutput("t6_new_strb", 64'(wr_strb), 64'hFF);
        applyStimulus();
        checkOutput("t6_new_done", 64'(done), 64'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
